serial_out: RTL

UART-style serial transmitter: the transmit-side counterpart of the team's digit receiver. It takes a packed BCD word and a digit count, and sends each digit as an ASCII character ('0' + nibble). Each character goes out as a 10-bit frame (start 0, 8 data bits LSB first, stop 1) at 16 clocks per bit. It sits between the number-producing logic and the board's serial TX pin, clocked from the same 9600×16 Hz clock as the receiver.

---
 rtl/serial_out.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/serial_out.sv
// rtl/serial_out.sv - BCD-to-ASCII UART transmitter, 10-bit frames at 16 clocks per bit.
// Optional CR/LF trailer frames are enabled by defining SERIAL_OUT_CRLF_EN.
module serial_out (
    input  logic        IN_clk,
    input  logic        IN_rst,
    input  logic        IN_start,
    input  logic [63:0] IN_data,
    input  logic [4:0]  IN_number,
    output logic        OUT_ser,
    output logic        OUT_busy,
    output logic        OUT_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [7:0]  char_q, char_d;
    logic [63:0] data_q, data_d;
    logic        ser_q, ser_d;
`ifdef SERIAL_OUT_CRLF_EN
    // 0: digits pending, 1: CR frame in flight, 2: LF frame in flight
    logic [1:0]  tail_q, tail_d;
`endif

    logic [4:0]  count;
    logic [4:0]  count_m1;
    logic [3:0]  first_ptr;
    logic [3:0]  ptr_m1;
    logic        baud_wrap;
    logic        accept;

    assign count     = (IN_number > 5'd16) ? 5'd16 : IN_number;
    assign count_m1  = count - 5'd1;
    assign first_ptr = (count == 5'd0) ? 4'd0 : count_m1[3:0];
    assign ptr_m1    = ptr_q - 4'd1;
    assign baud_wrap = (baud_q == 4'd15);
    assign accept    = (state_q == S_IDLE) && IN_start;

    always_ff @(posedge IN_clk or posedge IN_rst) begin
        if (IN_rst) begin
            state_q <= S_IDLE;
            baud_q  <= 4'd0;
            bit_q   <= 3'd0;
            ptr_q   <= 4'd0;
            char_q  <= 8'd0;
            data_q  <= 64'd0;
            ser_q   <= 1'b1;
`ifdef SERIAL_OUT_CRLF_EN
            tail_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            ptr_q   <= ptr_d;
            char_q  <= char_d;
            data_q  <= data_d;
            ser_q   <= ser_d;
`ifdef SERIAL_OUT_CRLF_EN
            tail_q  <= tail_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (IN_start) begin
`ifdef SERIAL_OUT_CRLF_EN
                    state_d = S_START;
`else
                    state_d = (count == 5'd0) ? S_DONE : S_START;
`endif
                end
            end
            S_START: begin
                if (baud_wrap) state_d = S_DATA;
            end
            S_DATA: begin
                if (baud_wrap && (bit_q == 3'd7)) state_d = S_STOP;
            end
            S_STOP: begin
                if (baud_wrap) begin
`ifdef SERIAL_OUT_CRLF_EN
                    state_d = ((ptr_q != 4'd0) || (tail_q != 2'd2)) ? S_START : S_DONE;
`else
                    state_d = (ptr_q != 4'd0) ? S_START : S_DONE;
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        baud_d = 4'd0;
        bit_d  = bit_q;
        ptr_d  = ptr_q;
        char_d = char_q;
        data_d = data_q;
`ifdef SERIAL_OUT_CRLF_EN
        tail_d = tail_q;
`endif

        // The baud counter only runs inside a frame, so it is zero on every acceptance edge
        if ((state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP)) begin
            baud_d = baud_q + 4'd1;
        end

        if ((state_q == S_DATA) && baud_wrap) begin
            bit_d = bit_q + 3'd1;
        end

        if (accept) begin
            data_d = IN_data;
            ptr_d  = first_ptr;
`ifdef SERIAL_OUT_CRLF_EN
            if (count == 5'd0) begin
                char_d = 8'h0D;
                tail_d = 2'd1;
            end else begin
                char_d = 8'h30 + {4'h0, IN_data[{first_ptr, 2'b00} +: 4]};
                tail_d = 2'd0;
            end
`else
            char_d = 8'h30 + {4'h0, IN_data[{first_ptr, 2'b00} +: 4]};
`endif
        end else if ((state_q == S_STOP) && (state_d == S_START)) begin
            if (ptr_q != 4'd0) begin
                ptr_d  = ptr_m1;
                char_d = 8'h30 + {4'h0, data_q[{ptr_m1, 2'b00} +: 4]};
            end
`ifdef SERIAL_OUT_CRLF_EN
            else if (tail_q == 2'd0) begin
                char_d = 8'h0D;
                tail_d = 2'd1;
            end else begin
                char_d = 8'h0A;
                tail_d = 2'd2;
            end
`endif
        end

        // The line level is registered from the next-state view so it changes on the same edge
        case (state_d)
            S_START: ser_d = 1'b0;
            S_DATA:  ser_d = char_d[bit_d];
            default: ser_d = 1'b1;
        endcase
    end

    assign OUT_ser  = ser_q;
    assign OUT_busy = (state_q != S_IDLE);
    assign OUT_done = (state_q == S_DONE);

endmodule
